ne8_shared_compare_sched: RTL and testbench

- Scheduler that time-shares one external 8-bit inequality comparator (NE8 carry-chain instance) between NREQ requesters.
- Each requester asks for a WIDTH-bit A!=B compare. The block picks a requester by round-robin, captures its operands, and steps them through the shared NE8 one byte slice per cycle.
- Returns a single registered NE result, tagged with the requester ID.
- Sits between requesting pipelines and the one NE8 instance in the datapath.

---
 rtl/ne8_shared_compare_sched.sv | 153 +++++++++++++++
 tb/tb_ne8_shared_compare_sched.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ne8_shared_compare_sched.sv
// Round-robin scheduler that time-shares one external NE8 byte comparator among NREQ requesters.
// Optional macro NE_SCHED_EARLY_EXIT_EN: end a compare on the first mismatching byte slice.
module ne8_shared_compare_sched #(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 32,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [7:0]            ne_i0,
  output logic [7:0]            ne_i1,
  input  logic                  ne_o,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_ne,
  output logic [IDW-1:0]        rsp_id,
  output logic                  busy
);

  localparam int              SLICES     = WIDTH / 8;
  localparam int              SW         = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IDW:0]    NREQ_W     = (IDW+1)'(NREQ);
  localparam logic [SW-1:0]   LAST_SLICE = SW'(SLICES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RSP  = 2'd2
  } state_t;

  state_t           state_q, next_state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   grant_id;
  logic [IDW-1:0]   grant_idx;
  logic             grant_found;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [SW-1:0]    slice_q;
  logic             result_q;
  logic             accept;
  logic             cmp_done;
  logic             rsp_done;
  logic             last_slice;

  // Search starts one past the last served requester and wraps modulo NREQ.
  always_comb begin : p_grant
    logic [IDW:0] cand;
    // NOTE: every variable driven here gets a default first so no path can infer a latch.
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(off);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!grant_found && req_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin : p_sel
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign last_slice = (slice_q == LAST_SLICE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= IDLE;
    end else begin
      state_q <= next_state;
    end
  end

  // READY is gated by resetn so no handshake can be signalled while reset is held.
  always_comb begin : p_fsm
    next_state = state_q;
    req_ready  = '0;
    accept     = 1'b0;
    cmp_done   = 1'b0;
    rsp_done   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_found && resetn) begin
          req_ready[grant_idx] = 1'b1;
          accept               = 1'b1;
          next_state           = CMP;
        end
      end
      CMP: begin
`ifdef NE_SCHED_EARLY_EXIT_EN
        cmp_done = ne_o || last_slice;
`else
        cmp_done = last_slice;
`endif
        if (cmp_done) next_state = RSP;
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_done   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: capture registers are ordinary flops, cleared so the slice outputs are defined after reset.
      a_q      <= '0;
      b_q      <= '0;
      grant_id <= '0;
      slice_q  <= '0;
      result_q <= 1'b0;
      rr_ptr   <= IDW'(NREQ - 1);
    end else begin
      if (accept) begin
        a_q      <= sel_a;
        b_q      <= sel_b;
        grant_id <= grant_idx;
        slice_q  <= '0;
        result_q <= 1'b0;
      end
      if (state_q == CMP) begin
        if (ne_o) result_q <= 1'b1;
        if (!cmp_done) slice_q <= slice_q + SW'(1);
      end
      if (rsp_done) rr_ptr <= grant_id;
    end
  end

  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == RSP);
  assign rsp_ne    = rsp_valid & result_q;
  assign rsp_id    = rsp_valid ? grant_id : '0;
  assign ne_i0     = (state_q == CMP) ? a_q[{slice_q, 3'b000} +: 8] : 8'h00;
  assign ne_i1     = (state_q == CMP) ? b_q[{slice_q, 3'b000} +: 8] : 8'h00;

endmodule

// File: tb/tb_ne8_shared_compare_sched.sv
// Self-checking bench for ne8_shared_compare_sched: vector table, directed corner cases, random traffic.
module tb_ne8_shared_compare_sched;

  localparam int NREQ   = 4;
  localparam int WIDTH  = 32;
  localparam int SLICES = 4;
`ifdef NE_SCHED_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  resetn = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a = '0;
  logic [NREQ*WIDTH-1:0] req_b = '0;
  logic [7:0]            ne_i0, ne_i1;
  logic                  ne_o;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b1;
  logic                  rsp_ne;
  logic [1:0]            rsp_id;
  logic                  busy;

  logic [1:0]            v64 = '0;
  logic [1:0]            r64;
  logic [127:0]          a64 = '0;
  logic [127:0]          b64 = '0;
  logic [7:0]            n64_i0, n64_i1;
  logic                  n64_o;
  logic                  rv64;
  logic                  rr64 = 1'b1;
  logic                  rne64;
  logic [0:0]            rid64;
  logic                  busy64;

  // Behavioural stand-ins for the shared NE8 comparator.
  assign ne_o  = (ne_i0 != ne_i1);
  assign n64_o = (n64_i0 != n64_i1);

  ne8_shared_compare_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) u_dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .ne_i0(ne_i0), .ne_i1(ne_i1), .ne_o(ne_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ne(rsp_ne), .rsp_id(rsp_id), .busy(busy)
  );

  ne8_shared_compare_sched #(.NREQ(2), .WIDTH(64)) u_dut64 (
    .clk(clk), .resetn(resetn), .req_valid(v64), .req_ready(r64),
    .req_a(a64), .req_b(b64), .ne_i0(n64_i0), .ne_i1(n64_i1), .ne_o(n64_o),
    .rsp_valid(rv64), .rsp_ready(rr64), .rsp_ne(rne64), .rsp_id(rid64), .busy(busy64)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int model_last = NREQ - 1;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic        ne;
    int          k;
    int          bp;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference rules: round-robin from the last served id; slice count from the first differing byte.
  function automatic int model_grant(input logic [NREQ-1:0] v);
    int g = -1;
    for (int off = 1; off <= NREQ; off++) begin
      int idx = (model_last + off) % NREQ;
      if (g < 0 && v[idx]) g = idx;
    end
    return g;
  endfunction

  function automatic int model_k(input logic [63:0] a, input logic [63:0] b, input int slices);
    int first = slices;
    for (int s = slices - 1; s >= 0; s--)
      if (a[s*8 +: 8] != b[s*8 +: 8]) first = s + 1;
    return EE ? first : slices;
  endfunction

  task automatic set_lane(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  // Called at a negedge with inputs already set; returns at the negedge after the response handshake.
  task automatic serve_one(input int exp_id, input logic exp_ne, input int exp_k,
                           input int bp, input bit drop);
    logic [31:0] a, b;
    int n = 0;
    #1;
    while (req_ready == '0 && n < 30) begin
      @(negedge clk); #1; n++;
    end
    if (req_ready == '0) begin
      check("accept_timeout", 64'(req_ready), 64'(1 << exp_id));
      return;
    end
    check("grant_onehot", 64'(req_ready), 64'(1 << exp_id));
    check("busy_in_idle", 64'(busy), 64'(0));
    a = req_a[exp_id*WIDTH +: WIDTH];
    b = req_b[exp_id*WIDTH +: WIDTH];
    @(posedge clk);
    @(negedge clk);
    req_a[exp_id*WIDTH +: WIDTH] = $urandom;
    req_b[exp_id*WIDTH +: WIDTH] = $urandom;
    if (drop) req_valid[exp_id] = 1'b0;
    for (int s = 0; s < exp_k; s++) begin
      if (s > 0) @(negedge clk);
      #1;
      check("slice_i0", 64'(ne_i0), 64'(a[s*8 +: 8]));
      check("slice_i1", 64'(ne_i1), 64'(b[s*8 +: 8]));
      check("cmp_busy", 64'(busy), 64'(1));
      check("cmp_no_rsp", 64'(rsp_valid), 64'(0));
      check("cmp_no_ready", 64'(req_ready), 64'(0));
    end
    @(negedge clk);
    rsp_ready = (bp == 0);
    #1;
    check("rsp_valid", 64'(rsp_valid), 64'(1));
    check("rsp_ne", 64'(rsp_ne), 64'(exp_ne));
    check("rsp_id", 64'(rsp_id), 64'(exp_id));
    check("rsp_no_ready", 64'(req_ready), 64'(0));
    check("rsp_idle_slice", 64'(ne_i0), 64'(0));
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      if (i == bp - 1) rsp_ready = 1'b1;
      #1;
      check("bp_valid_hold", 64'(rsp_valid), 64'(1));
      check("bp_ne_hold", 64'(rsp_ne), 64'(exp_ne));
      check("bp_id_hold", 64'(rsp_id), 64'(exp_id));
      check("bp_no_ready", 64'(req_ready), 64'(0));
    end
    model_last = exp_id;
    @(negedge clk);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stim
    logic [63:0] w64_a;
    logic [31:0] ra, rb;
    int          gid;

    vecs[0] = '{id: 2, a: 32'hDEADBEEF, b: 32'hDEADBEEF, ne: 1'b0, k: 4,            bp: 0};
    vecs[1] = '{id: 0, a: 32'h00000001, b: 32'h00000000, ne: 1'b1, k: EE ? 1 : 4, bp: 0};
    vecs[2] = '{id: 3, a: 32'h80000000, b: 32'h00000000, ne: 1'b1, k: 4,            bp: 0};
    vecs[3] = '{id: 1, a: 32'h12340000, b: 32'h12350000, ne: 1'b1, k: EE ? 3 : 4, bp: 10};
    vecs[4] = '{id: 1, a: 32'h00000000, b: 32'h00000000, ne: 1'b0, k: 4,            bp: 2};
    vecs[5] = '{id: 3, a: 32'hA5A5A5A5, b: 32'hA5A5A5A4, ne: 1'b1, k: EE ? 1 : 4, bp: 1};

    // Reset values, with requests pending to show READY stays low.
    req_valid = '1;
    @(negedge clk); #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_ne", 64'(rsp_ne), 64'(0));
    check("rst_rsp_id", 64'(rsp_id), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_ne_i0", 64'(ne_i0), 64'(0));
    check("rst_ne_i1", 64'(ne_i1), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    @(negedge clk);
    req_valid = '0;
    resetn = 1'b1;

    // No requests: everything stays idle.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("idle_ready", 64'(req_ready), 64'(0));
      check("idle_busy", 64'(busy), 64'(0));
      check("idle_rsp", 64'(rsp_valid), 64'(0));
    end

    // All requesters valid: grants rotate 0,1,2,3,0.
    for (int i = 0; i < NREQ; i++)
      set_lane(i, {4{8'(i + 1)}}, (i % 2 == 0) ? {4{8'(i + 1)}} : {8'(i), {3{8'(i + 1)}}});
    req_valid = '1;
    for (int j = 0; j < 5; j++) begin
      ra = req_a[(j % NREQ)*WIDTH +: WIDTH];
      rb = req_b[(j % NREQ)*WIDTH +: WIDTH];
      serve_one(j % NREQ, ra != rb, model_k(64'(ra), 64'(rb), SLICES), 0, 1'b0);
    end
    req_valid = '0;

    // Vector table: single requester, fixed operands and response backpressure.
    for (int v = 0; v < 6; v++) begin
      set_lane(vecs[v].id, vecs[v].a, vecs[v].b);
      req_valid = NREQ'(1 << vecs[v].id);
      serve_one(vecs[v].id, vecs[v].ne, vecs[v].k, vecs[v].bp, 1'b1);
      req_valid = '0;
    end

    // Random traffic against the reference rules.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        ra = $urandom;
        case ($urandom_range(0, 3))
          0, 1:    rb = ra;
          2:       rb = ra ^ (32'h1 << $urandom_range(0, 31));
          default: rb = $urandom;
        endcase
        set_lane(i, ra, rb);
      end
      req_valid = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      gid = model_grant(req_valid);
      ra = req_a[gid*WIDTH +: WIDTH];
      rb = req_b[gid*WIDTH +: WIDTH];
      serve_one(gid, ra != rb, model_k(64'(ra), 64'(rb), SLICES), $urandom_range(0, 3),
                1'($urandom_range(0, 1)));
    end
    req_valid = '0;

    // Reset during slice 1 of a mismatching compare discards it and restores priority to req 0.
    @(negedge clk);
    set_lane(2, 32'hFF000000, 32'h00000000);
    req_valid = 4'b0100;
    #1;
    check("mid_rst_accept", 64'(req_ready), 64'(4'b0100));
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk); #1;
    check("mid_rst_slice1", 64'(ne_i0), 64'(8'h00));
    check("mid_rst_slice1_busy", 64'(busy), 64'(1));
    resetn = 1'b0;
    #1;
    check("mid_rst_rsp", 64'(rsp_valid), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_i1", 64'(ne_i1), 64'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("mid_rst_no_rsp", 64'(rsp_valid), 64'(0));
    end
    resetn = 1'b1;
    model_last = NREQ - 1;
    @(negedge clk); #1;
    check("post_rst_no_rsp", 64'(rsp_valid), 64'(0));
    set_lane(0, 32'h0000CAFE, 32'h0000CAFE);
    set_lane(3, 32'h11111111, 32'h22222222);
    req_valid = 4'b1001;
    serve_one(0, 1'b0, 4, 0, 1'b1);
    req_valid = '0;

    // 64-bit instance: mismatch only in the top byte needs all eight slices.
    w64_a = 64'h8000_0000_0000_0000;
    a64[63:0] = w64_a;
    v64 = 2'b01;
    #1;
    check("w64_accept", 64'(r64), 64'(2'b01));
    @(posedge clk);
    @(negedge clk);
    v64 = '0;
    for (int s = 0; s < 8; s++) begin
      if (s > 0) @(negedge clk);
      #1;
      check("w64_cmp_no_rsp", 64'(rv64), 64'(0));
      check("w64_slice_i0", 64'(n64_i0), 64'(w64_a[s*8 +: 8]));
    end
    @(negedge clk); #1;
    check("w64_rsp_valid", 64'(rv64), 64'(1));
    check("w64_rsp_ne", 64'(rne64), 64'(1));
    check("w64_rsp_id", 64'(rid64), 64'(0));
    @(negedge clk); #1;
    check("w64_back_idle", 64'(busy64), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
